// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the half-precision adder entry sequencer.
package fp_seq_pkg;

  localparam int unsigned OP_W = 16;

  localparam logic [3:0] KEY_SHIFT = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd14;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic [1:0] SC_LOAD_A = 2'b00;
  localparam logic [1:0] SC_LOAD_B = 2'b01;
  localparam logic [1:0] SC_BUSY   = 2'b10;
  localparam logic [1:0] SC_DONE   = 2'b11;

  // ISSUE and WAIT share one display code.
  function automatic logic [1:0] state_code_of(input state_e s);
    case (s)
      LOAD_A:      return SC_LOAD_A;
      LOAD_B:      return SC_LOAD_B;
      ISSUE, WAIT: return SC_BUSY;
      default:     return SC_DONE;
    endcase
  endfunction

endpackage

// File: rtl/fp_key_decode.sv
// Keypad index to hex digit / command decode; shift promotes C->E and D->F.
module fp_key_decode
  import fp_seq_pkg::*;
(
  input  logic [3:0] key_code,
  input  logic       shift,
  output logic       is_digit,
  output logic       is_enter,
  output logic       is_shift,
  output logic [3:0] digit
);

  // Map the 4x4 keypad layout onto digit values and command keys.
  always_comb begin
    is_digit = 1'b1;
    is_enter = 1'b0;
    is_shift = 1'b0;
    digit    = '0;
    case (key_code)
      4'd0:      digit = 4'h1;
      4'd1:      digit = 4'h2;
      4'd2:      digit = 4'h3;
      4'd3:      digit = 4'hA;
      4'd4:      digit = 4'h4;
      4'd5:      digit = 4'h5;
      4'd6:      digit = 4'h6;
      4'd7:      digit = 4'hB;
      4'd8:      digit = 4'h7;
      4'd9:      digit = 4'h8;
      4'd10:     digit = 4'h9;
      4'd11:     digit = shift ? 4'hE : 4'hC;
      KEY_SHIFT: begin
        is_digit = 1'b0;
        is_shift = 1'b1;
      end
      4'd13:     digit = 4'h0;
      KEY_ENTER: begin
        is_digit = 1'b0;
        is_enter = 1'b1;
      end
      default:   digit = shift ? 4'hF : 4'hD;
    endcase
  end

endmodule

// File: rtl/fp_entry_sequencer.sv
// Keypad-driven operand entry and single-add issue for the half-precision
// adder pipeline, with result capture and WAIT timeout.
// Optional: define FPSEQ_CHAIN_EN so ENTER in DONE reloads op_a from the
// result (running accumulation); otherwise ENTER in DONE is ignored.
module fp_entry_sequencer
  import fp_seq_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 32,
  parameter int unsigned TO_W        = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic            res_valid,
  input  logic [OP_W-1:0] res_sum,
  input  logic            res_over,
  output logic            op_valid,
  output logic [OP_W-1:0] op_a,
  output logic [OP_W-1:0] op_b,
  output logic [OP_W-1:0] entry_value,
  output logic [2:0]      entry_count,
  output logic [1:0]      state_code,
  output logic            busy,
  output logic [OP_W-1:0] result,
  output logic            result_valid,
  output logic            over_flag,
  output logic            timeout_err
);

  state_e            state_q, state_d;
  logic              key_prev_q, key_prev_d;
  logic              shift_q, shift_d;
  logic [OP_W-1:0]   entry_q, entry_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]   result_q, result_d;
  logic              over_q, over_d;
  logic              terr_q, terr_d;

  logic              key_ev;
  logic              dec_is_digit, dec_is_enter, dec_is_shift;
  logic [3:0]        dec_digit;

  assign key_ev = key_valid & ~key_prev_q;

  fp_key_decode u_dec (
    .key_code (key_code),
    .shift    (shift_q),
    .is_digit (dec_is_digit),
    .is_enter (dec_is_enter),
    .is_shift (dec_is_shift),
    .digit    (dec_digit)
  );

  // State, entry, operand, result and timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD_A;
      key_prev_q <= 1'b0;
      shift_q    <= 1'b0;
      entry_q    <= '0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      over_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_prev_d;
      shift_q    <= shift_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      over_q     <= over_d;
      terr_q     <= terr_d;
    end
  end

  // Next-state and datapath updates driven by key events and adder results.
  always_comb begin
    state_d    = state_q;
    key_prev_d = key_valid;
    shift_d    = shift_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    to_cnt_d   = to_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    over_d     = over_q;
    terr_d     = terr_q;

    // Any key event consumes a pending shift, even one ignored in WAIT.
    if (key_ev) shift_d = 1'b0;

    case (state_q)
      LOAD_A, LOAD_B: begin
        if (key_ev) begin
          if (dec_is_shift) begin
            shift_d = 1'b1;
          end else if (dec_is_digit) begin
            if (cnt_q < 3'(DIGITS)) begin
              entry_d = {entry_q[OP_W-5:0], dec_digit};
              cnt_d   = cnt_q + 3'd1;
            end
          end else if (dec_is_enter) begin
            entry_d = '0;
            cnt_d   = '0;
            if (state_q == LOAD_A) begin
              op_a_d  = entry_q;
              state_d = LOAD_B;
            end else begin
              op_b_d  = entry_q;
              state_d = ISSUE;
            end
          end
        end
      end

      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end

      WAIT: begin
        if (res_valid) begin
          result_d = res_sum;
          over_d   = res_over;
          state_d  = DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          terr_d   = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      DONE: begin
        if (key_ev) begin
          if (dec_is_shift) begin
            shift_d = 1'b1;
          end else if (dec_is_digit) begin
            entry_d = {{(OP_W-4){1'b0}}, dec_digit};
            cnt_d   = 3'd1;
            terr_d  = 1'b0;
            over_d  = 1'b0;
            state_d = LOAD_A;
          end else if (dec_is_enter) begin
`ifdef FPSEQ_CHAIN_EN
            if (!terr_q) begin
              op_a_d  = result_q;
              entry_d = '0;
              cnt_d   = '0;
              state_d = LOAD_B;
            end
`endif
          end
        end
      end

      default: state_d = LOAD_A;
    endcase
  end

  assign op_valid     = (state_q == ISSUE);
  assign busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign result_valid = (state_q == DONE);
  assign state_code   = state_code_of(state_q);
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign entry_value  = entry_q;
  assign entry_count  = cnt_q;
  assign result       = result_q;
  assign over_flag    = over_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_fp_entry_sequencer.sv
// Directed bench for fp_entry_sequencer: key-entry table plus hand-written
// multi-cycle sequences (issue, timeout, final-cycle result, resets).
module tb_fp_entry_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        res_valid;
  logic [15:0] res_sum;
  logic        res_over;
  logic        op_valid;
  logic [15:0] op_a, op_b, entry_value, result;
  logic [2:0]  entry_count;
  logic [1:0]  state_code;
  logic        busy, result_valid, over_flag, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  fp_entry_sequencer #(.DIGITS(4), .TIMEOUT_CYC(32), .TO_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .res_valid    (res_valid),
    .res_sum      (res_sum),
    .res_over     (res_over),
    .op_valid     (op_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .entry_value  (entry_value),
    .entry_count  (entry_count),
    .state_code   (state_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .over_flag    (over_flag),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic [1:0]  st;
    logic [15:0] opa;
    logic        ov;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".op_valid"},     16'(op_valid),     16'h0);
    chk({tag, ".op_a"},         op_a,              16'h0);
    chk({tag, ".op_b"},         op_b,              16'h0);
    chk({tag, ".entry_value"},  entry_value,       16'h0);
    chk({tag, ".entry_count"},  16'(entry_count),  16'h0);
    chk({tag, ".state_code"},   16'(state_code),   16'h0);
    chk({tag, ".busy"},         16'(busy),         16'h0);
    chk({tag, ".result"},       result,            16'h0);
    chk({tag, ".result_valid"}, 16'(result_valid), 16'h0);
    chk({tag, ".over_flag"},    16'(over_flag),    16'h0);
    chk({tag, ".timeout_err"},  16'(timeout_err),  16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic early;

    // key, entry, count, state, op_a, op_valid
    tbl[0] = '{4'd2,  16'h0003, 3'd1, 2'b00, 16'h0000, 1'b0};
    tbl[1] = '{4'd11, 16'h003C, 3'd2, 2'b00, 16'h0000, 1'b0};
    tbl[2] = '{4'd13, 16'h03C0, 3'd3, 2'b00, 16'h0000, 1'b0};
    tbl[3] = '{4'd13, 16'h3C00, 3'd4, 2'b00, 16'h0000, 1'b0};
    tbl[4] = '{4'd14, 16'h0000, 3'd0, 2'b01, 16'h3C00, 1'b0};
    tbl[5] = '{4'd4,  16'h0004, 3'd1, 2'b01, 16'h3C00, 1'b0};
    tbl[6] = '{4'd13, 16'h0040, 3'd2, 2'b01, 16'h3C00, 1'b0};
    tbl[7] = '{4'd13, 16'h0400, 3'd3, 2'b01, 16'h3C00, 1'b0};
    tbl[8] = '{4'd13, 16'h4000, 3'd4, 2'b01, 16'h3C00, 1'b0};
    tbl[9] = '{4'd14, 16'h0000, 3'd0, 2'b10, 16'h3C00, 1'b1};

    reset = 1'b1; key_valid = 1'b0; key_code = '0;
    res_valid = 1'b0; res_sum = '0; res_over = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset("rst0");

    // Operand entry 3C00 / 4000 from the table.
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].key);
      chk($sformatf("tbl%0d.entry", i), entry_value,         tbl[i].entry);
      chk($sformatf("tbl%0d.cnt", i),   16'(entry_count),    16'(tbl[i].cnt));
      chk($sformatf("tbl%0d.state", i), 16'(state_code),     16'(tbl[i].st));
      chk($sformatf("tbl%0d.op_a", i),  op_a,                tbl[i].opa);
      chk($sformatf("tbl%0d.op_valid", i), 16'(op_valid),    16'(tbl[i].ov));
    end
    chk("issue.op_b", op_b, 16'h4000);
    @(negedge clk);
    chk("wait.op_valid_low", 16'(op_valid), 16'h0);
    chk("wait.busy", 16'(busy), 16'h1);
    res_valid = 1'b1; res_sum = 16'h4200; res_over = 1'b0;
    @(negedge clk);
    res_valid = 1'b0;
    chk("done.result", result, 16'h4200);
    chk("done.result_valid", 16'(result_valid), 16'h1);
    chk("done.state", 16'(state_code), 16'h3);
    chk("done.busy", 16'(busy), 16'h0);
    chk("done.op_a_held", op_a, 16'h3C00);

    // ENTER in DONE: chain reload or ignored.
    press(4'd14);
`ifdef FPSEQ_CHAIN_EN
    chk("chain.state", 16'(state_code), 16'h1);
    chk("chain.op_a", op_a, 16'h4200);
    press(4'd14);
`else
    chk("nochain.state", 16'(state_code), 16'h3);
    chk("nochain.op_a", op_a, 16'h3C00);
    press(4'd13);
    chk("nochain.digit_to_loada", 16'(state_code), 16'h0);
    press(4'd14);
    press(4'd14);
`endif
    chk("to.op_valid", 16'(op_valid), 16'h1);

    // Timeout: 32 WAIT cycles without error, then error with zeroed result.
    early = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (timeout_err || !busy) early = 1'b1;
    end
    chk("to.no_early_timeout", 16'(early), 16'h0);
    @(negedge clk);
    chk("to.timeout_err", 16'(timeout_err), 16'h1);
    chk("to.result_zero", result, 16'h0);
    chk("to.state", 16'(state_code), 16'h3);
    chk("to.result_valid", 16'(result_valid), 16'h1);

    press(4'd14);
    chk("to.enter_ignored", 16'(state_code), 16'h3);
    press(4'd5);
    chk("to.digit_clears_err", 16'(timeout_err), 16'h0);
    chk("to.digit_entry", entry_value, 16'h0005);
    chk("to.digit_state", 16'(state_code), 16'h0);

    // Result on the final WAIT cycle beats the timeout.
    press(4'd14);
    press(4'd14);
    chk("last.op_valid", 16'(op_valid), 16'h1);
    chk("last.op_a", op_a, 16'h0005);
    repeat (32) @(negedge clk);
    res_valid = 1'b1; res_sum = 16'h5A5A; res_over = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("last.result", result, 16'h5A5A);
    chk("last.over", 16'(over_flag), 16'h1);
    chk("last.no_err", 16'(timeout_err), 16'h0);
    chk("last.state", 16'(state_code), 16'h3);

    // res_valid outside WAIT is ignored.
    @(negedge clk);
    res_valid = 1'b1; res_sum = 16'h1111; res_over = 1'b0;
    @(negedge clk);
    res_valid = 1'b0;
    chk("stray.result", result, 16'h5A5A);
    chk("stray.over", 16'(over_flag), 16'h1);

    do_reset();
    check_reset("rst1");

    // Shift: *,C,4,ENTER -> 00E4; then *,D -> F.
    press(4'd12);
    press(4'd11);
    press(4'd4);
    press(4'd14);
    chk("shift.op_a", op_a, 16'h00E4);
    chk("shift.state", 16'(state_code), 16'h1);
    press(4'd12);
    press(4'd15);
    chk("shiftD.entry", entry_value, 16'h000F);
    press(4'd11);
    chk("shift_cleared.entry", entry_value, 16'h00FC);
    chk("shift_cleared.cnt", 16'(entry_count), 16'h2);

    // Reset mid-entry in LOAD_B.
    do_reset();
    check_reset("rst_loadb");

    // Six digits: only the first four are kept.
    press(4'd0); press(4'd1); press(4'd2);
    press(4'd4); press(4'd5); press(4'd6);
    chk("six.entry", entry_value, 16'h1234);
    chk("six.cnt", 16'(entry_count), 16'h4);
    press(4'd14);
    chk("six.op_a", op_a, 16'h1234);

    do_reset();
    // key_valid held high: a single event.
    @(negedge clk);
    key_code = 4'd5; key_valid = 1'b1;
    repeat (5) @(negedge clk);
    key_valid = 1'b0;
    chk("hold.entry", entry_value, 16'h0005);
    chk("hold.cnt", 16'(entry_count), 16'h1);

    // Reset during WAIT, then a late result is ignored.
    press(4'd14);
    press(4'd14);
    @(negedge clk);
    chk("rstwait.busy", 16'(busy), 16'h1);
    do_reset();
    res_valid = 1'b1; res_sum = 16'h7777; res_over = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    check_reset("rst_wait");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
